alu_shift_pipe: RTL and testbench

//   Pipelined, parametrised barrel shifter for the ALU shift/rotate path.

---
 rtl/alu_shift_pipe.sv | 179 +++++++++++++++++
 tb/tb_alu_shift_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_pipe.sv
// Pipelined log barrel shifter for the ALU shift/rotate path (ROR/ROL/LSR/LSL/ASR, valid/ready).
// Optional carry/zero flags are built when ALU_SHIFT_FLAGS_EN is defined.
module alu_shift_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [SHW-1:0]   amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
`ifdef ALU_SHIFT_FLAGS_EN
    ,
    output logic             flag_c,
    output logic             flag_z
`endif
);

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_LSR = 3'b010;
    localparam logic [2:0] OP_LSL = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    logic             advance;
    logic             init_q;

    logic             vld_q  [SHW];
    logic [WIDTH-1:0] data_q [SHW];
    logic [2:0]       op_q   [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic             sgn_q  [SHW];
    logic [WIDTH-1:0] step_data [SHW];

    logic             out_valid_q;
    logic [WIDTH-1:0] dout_q;

`ifdef ALU_SHIFT_FLAGS_EN
    logic             carry_q    [SHW];
    logic             step_carry [SHW];
    logic             flag_c_q;
    logic             flag_z_q;
`endif

    // Whole pipe moves together; it only holds when the result is waiting on downstream.
    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance && init_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
`ifdef ALU_SHIFT_FLAGS_EN
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
`endif

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op_v,
        input logic             sgn,
        input int               s
    );
        logic [WIDTH-1:0] fill;
        fill = sgn ? ~({WIDTH{1'b1}} >> s) : '0;
        case (op_v)
            OP_ROR:  return (x >> s) | (x << (WIDTH - s));
            OP_ROL:  return (x << s) | (x >> (WIDTH - s));
            OP_LSR:  return x >> s;
            OP_LSL:  return x << s;
            OP_ASR:  return (x >> s) | fill;
            default: return x;
        endcase
    endfunction

    // Carry is the last bit to leave the word, so each applied step overwrites it.
    function automatic logic carry_step(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] res,
        input logic [2:0]       op_v,
        input int               s,
        input logic             cin
    );
        logic [WIDTH-1:0] t;
        t = '0;
        case (op_v)
            OP_ROR: return res[WIDTH-1];
            OP_ROL: return res[0];
            OP_LSR, OP_ASR: begin
                t = x >> (s - 1);
                return t[0];
            end
            OP_LSL: begin
                t = x >> (WIDTH - s);
                return t[0];
            end
            default: return cin;
        endcase
    endfunction

`ifdef ALU_SHIFT_FLAGS_EN
    always_comb begin
        for (int j = 0; j < SHW; j++) begin
            step_data[j]  = data_q[j];
            step_carry[j] = carry_q[j];
            if (amt_q[j][0]) begin
                step_data[j]  = shift_step(data_q[j], op_q[j], sgn_q[j], 1 << j);
                step_carry[j] = carry_step(data_q[j], step_data[j], op_q[j], 1 << j, carry_q[j]);
            end
        end
    end
`else
    always_comb begin
        for (int j = 0; j < SHW; j++) begin
            step_data[j] = data_q[j];
            if (amt_q[j][0]) begin
                step_data[j] = shift_step(data_q[j], op_q[j], sgn_q[j], 1 << j);
            end
        end
    end
`endif

    // p0 captures the operand; stage j applies a 2^j shift when its remaining amount LSB is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            data_q[0] <= operand1;
            op_q[0]   <= op;
            amt_q[0]  <= amount;
            sgn_q[0]  <= operand1[WIDTH-1];
`ifdef ALU_SHIFT_FLAGS_EN
            carry_q[0] <= 1'b0;
`endif
            for (int j = 1; j < SHW; j++) begin
                data_q[j] <= step_data[j-1];
                op_q[j]   <= op_q[j-1];
                amt_q[j]  <= amt_q[j-1] >> 1;
                sgn_q[j]  <= sgn_q[j-1];
`ifdef ALU_SHIFT_FLAGS_EN
                carry_q[j] <= step_carry[j-1];
`endif
            end
        end
    end

    // Output stage and control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            for (int j = 0; j < SHW; j++) begin
                vld_q[j] <= 1'b0;
            end
`ifdef ALU_SHIFT_FLAGS_EN
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
`endif
        end else begin
            init_q <= 1'b1;
            if (advance) begin
                vld_q[0] <= in_valid && init_q;
                for (int j = 1; j < SHW; j++) begin
                    vld_q[j] <= vld_q[j-1];
                end
                out_valid_q <= vld_q[SHW-1];
                if (vld_q[SHW-1]) begin
                    dout_q <= step_data[SHW-1];
`ifdef ALU_SHIFT_FLAGS_EN
                    flag_c_q <= step_carry[SHW-1];
                    flag_z_q <= (step_data[SHW-1] == '0);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe at WIDTH=16; flag checks only when ALU_SHIFT_FLAGS_EN is defined.
module tb_alu_shift_pipe;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [2:0]    op        = 3'd0;
    logic [W-1:0]  operand1  = '0;
    logic [SW-1:0] amount    = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  dout;
`ifdef ALU_SHIFT_FLAGS_EN
    logic          flag_c;
    logic          flag_z;
`endif

    alu_shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand1  (operand1),
        .amount    (amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef ALU_SHIFT_FLAGS_EN
        ,
        .flag_c    (flag_c),
        .flag_z    (flag_z)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W:0]   sbq[$];
    int           out_cyc[$];
    logic [W:0]   mon_exp;
    bit           rnd_bp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: bit-index definition of each op; result in [W-1:0], carry in [W].
    function automatic logic [W:0] ref_shift(input logic [2:0] o, input logic [W-1:0] d, input int n);
        logic [W-1:0] r;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            case (o)
                3'd0:    r[i] = d[(i + n) % W];
                3'd1:    r[i] = d[(i - n + W) % W];
                3'd2:    r[i] = (i + n < W) ? d[(i + n) % W] : 1'b0;
                3'd3:    r[i] = (i >= n) ? d[(i - n + W) % W] : 1'b0;
                3'd4:    r[i] = (i + n < W) ? d[(i + n) % W] : d[W-1];
                default: r[i] = d[i];
            endcase
        end
        if (n != 0 && o <= 3'd4) begin
            case (o)
                3'd0:    c = r[W-1];
                3'd1:    c = r[0];
                3'd3:    c = d[W-n];
                default: c = d[n-1];
            endcase
        end
        return {c, r};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && in_valid && in_ready)
            sbq.push_back(ref_shift(op, operand1, int'(amount)));
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                mon_exp = sbq.pop_front();
                chk("dout", 32'(dout), 32'(mon_exp[W-1:0]));
`ifdef ALU_SHIFT_FLAGS_EN
                chk("flag_c", 32'(flag_c), 32'(mon_exp[W]));
                chk("flag_z", 32'(flag_z), 32'(mon_exp[W-1:0] == '0));
`endif
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] d, input logic [SW-1:0] a);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        op       = o;
        operand1 = d;
        amount   = a;
        while (!acc && tries < 200) begin
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op       = 3'($urandom);
        operand1 = W'($urandom);
        amount   = SW'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // 1: ROR latency and value
        send(3'b000, 16'h8001, 4'd1);
        idle();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_dout", 32'(dout), 32'h0000_C000);
`ifdef ALU_SHIFT_FLAGS_EN
        chk("t1_c", 32'(flag_c), 32'd1);
        chk("t1_z", 32'(flag_z), 32'd0);
`endif
        drain();

        // 2: fill behaviour at maximum distance
        send(3'b100, 16'h8000, 4'd15);
        send(3'b010, 16'h8000, 4'd15);
        send(3'b011, 16'h0001, 4'd15);
        idle();
        drain();

        // 3: back-to-back ROL
        out_cyc.delete();
        for (int k = 0; k < 16; k++) begin
            chk("t3_in_ready", 32'(in_ready), 32'd1);
            send(3'b001, 16'h0001, SW'(k));
        end
        idle();
        drain();
        chk("t3_count", 32'(out_cyc.size()), 32'd16);
        if (out_cyc.size() == 16)
            chk("t3_no_gaps", 32'(out_cyc[15] - out_cyc[0]), 32'd15);

        // 4: backpressure with a full pipe
        out_cyc.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(3'($urandom_range(0, 4)), W'($urandom), SW'(k + 3));
        idle();
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_dout_held", 32'(dout), 32'(sbq[0][W-1:0]));
            @(posedge clk);
            #1;
        end
        drain();
        chk("t4_count", 32'(out_cyc.size()), 32'd5);

        // 5: reset with ops in flight
        send(3'b011, 16'h00F0, 4'd2);
        send(3'b000, 16'h1234, 4'd4);
        send(3'b100, 16'hF00F, 4'd3);
        idle();
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("t5_no_stale", 32'(out_valid), 32'd0);
        end
        send(3'b100, 16'h8000, 4'd15);
        idle();
        drain();

        // 6: zero result with carry, pass-through op
        send(3'b010, 16'h0003, 4'd2);
        send(3'b111, 16'hA5A5, 4'd5);
        idle();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t6_lsr_zero", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        chk("t6_pass", 32'(dout), 32'h0000_A5A5);
        drain();

        // Random ops under random backpressure
        rnd_bp = 1'b1;
        for (int k = 0; k < 40; k++)
            send(3'($urandom_range(0, 7)), W'($urandom), SW'($urandom));
        rnd_bp = 1'b0;
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
